// File: rtl/snake_core.sv
// Snake game engine: 40x30 grid of 16x16 cells, frame-locked stepping, LFSR food placement,
// and a registered per-pixel colour output for a 640x480 VGA timing generator.
module snake_core #(
    parameter int MOVE_DIV = 8,
    parameter int MAX_LEN  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        display,
    input  logic        animate,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        start,
    output logic [11:0] rgb,
    output logic [7:0]  score,
    output logic        game_over,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {IDLE, RUN, PLACE_FOOD, OVER} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    localparam int              LW        = $clog2(MAX_LEN + 1);
    localparam logic [LW-1:0]   LEN_MAX   = LW'(MAX_LEN);
    localparam logic [LW-1:0]   LEN_INIT  = LW'(3);
    localparam logic [7:0]      STEP_LAST = 8'(MOVE_DIV - 1);

    state_t        state;
    dir_t          dir;
    dir_t          pend;
    logic [5:0]    seg_x [MAX_LEN];
    logic [4:0]    seg_y [MAX_LEN];
    logic [LW-1:0] len;
    logic [5:0]    food_x;
    logic [4:0]    food_y;
    logic [7:0]    step_cnt;
    logic [15:0]   lfsr;
    logic          animate_q;
    logic          start_q;

    logic          frame_tick;
    logic          start_rise;
    logic          step;
    logic          lfsr_fb;
    dir_t          dir_eff;
    dir_t          req;
    logic          req_valid;
    logic          req_ok;
    logic [5:0]    nh_x;
    logic [4:0]    nh_y;
    logic          wall_hit;
    logic          self_hit;
    logic          eat;
    logic [5:0]    cand_x;
    logic [4:0]    cand_y;
    logic          cand_on_snake;
    logic          cand_ok;
    logic [5:0]    cx;
    logic [4:0]    cy;
    logic          on_head;
    logic          on_body;
    logic          on_food;
    logic [11:0]   pix_rgb;
    logic          unused_bits;

    assign state_dbg   = state;
    assign unused_bits = ^x[3:0];

    assign frame_tick = animate & ~animate_q & (y == 10'd480);
    assign start_rise = start & ~start_q;
    assign step       = (state == RUN) && frame_tick && (step_cnt == STEP_LAST);
    assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_UP:   return DIR_DOWN;
            DIR_DOWN: return DIR_UP;
            DIR_LEFT: return DIR_RIGHT;
            default:  return DIR_LEFT;
        endcase
    endfunction

    // On a step cycle the pending direction becomes current, so judge reversals against it.
    assign dir_eff = step ? pend : dir;

    always_comb begin
        req_valid = 1'b1;
        req       = DIR_RIGHT;
        if (btn_up)         req = DIR_UP;
        else if (btn_down)  req = DIR_DOWN;
        else if (btn_left)  req = DIR_LEFT;
        else if (btn_right) req = DIR_RIGHT;
        else                req_valid = 1'b0;
    end

    assign req_ok = req_valid && (req != opposite(dir_eff));

    always_comb begin
        nh_x     = seg_x[0];
        nh_y     = seg_y[0];
        wall_hit = 1'b0;
        case (pend)
            DIR_UP: begin
                if (seg_y[0] == 5'd0) wall_hit = 1'b1;
                else                  nh_y = seg_y[0] - 5'd1;
            end
            DIR_DOWN: begin
                if (seg_y[0] == 5'd29) wall_hit = 1'b1;
                else                   nh_y = seg_y[0] + 5'd1;
            end
            DIR_LEFT: begin
                if (seg_x[0] == 6'd0) wall_hit = 1'b1;
                else                  nh_x = seg_x[0] - 6'd1;
            end
            default: begin
                if (seg_x[0] == 6'd39) wall_hit = 1'b1;
                else                   nh_x = seg_x[0] + 6'd1;
            end
        endcase
    end

    // The tail segment moves away on this step, so it is excluded from the self-collision test.
    always_comb begin
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN - 1; i++) begin
            if ((i + 1 < int'(len)) && (seg_x[i] == nh_x) && (seg_y[i] == nh_y))
                self_hit = 1'b1;
        end
    end

    assign eat = (nh_x == food_x) && (nh_y == food_y);

    assign cand_x = lfsr[5:0];
    assign cand_y = lfsr[12:8];

    always_comb begin
        cand_on_snake = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((i < int'(len)) && (seg_x[i] == cand_x) && (seg_y[i] == cand_y))
                cand_on_snake = 1'b1;
        end
    end

    assign cand_ok = (cand_x < 6'd40) && (cand_y < 5'd30) && !cand_on_snake;

    assign cx      = x[9:4];
    assign cy      = y[8:4];
    assign on_head = (seg_x[0] == cx) && (seg_y[0] == cy);
    assign on_food = (food_x == cx) && (food_y == cy);

    always_comb begin
        on_body = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((i < int'(len)) && (seg_x[i] == cx) && (seg_y[i] == cy))
                on_body = 1'b1;
        end
    end

    always_comb begin
        pix_rgb = 12'h000;
        if (!display)            pix_rgb = 12'h000;
        else if (on_head)        pix_rgb = 12'h0F0;
        else if (on_body)        pix_rgb = 12'h070;
        else if (on_food)        pix_rgb = 12'hF00;
        else if (state == OVER)  pix_rgb = 12'h300;
        else                     pix_rgb = 12'h000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dir       <= DIR_RIGHT;
            pend      <= DIR_RIGHT;
            len       <= LEN_INIT;
            food_x    <= 6'd30;
            food_y    <= 5'd15;
            step_cnt  <= 8'd0;
            score     <= 8'd0;
            game_over <= 1'b0;
            rgb       <= 12'h000;
            lfsr      <= 16'hACE1;
            animate_q <= 1'b0;
            start_q   <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= (i < 3) ? 6'(20 - i) : 6'd0;
                seg_y[i] <= (i < 3) ? 5'd15 : 5'd0;
            end
        end else begin
            lfsr      <= {lfsr[14:0], lfsr_fb};
            animate_q <= animate;
            start_q   <= start;
            rgb       <= pix_rgb;
            if (req_ok)
                pend <= req;

            case (state)
                IDLE: begin
                    if (start_rise)
                        state <= RUN;
                end
                RUN: begin
                    if (frame_tick) begin
                        if (step) begin
                            step_cnt <= 8'd0;
                            dir      <= pend;
                            if (wall_hit || self_hit) begin
                                state     <= OVER;
                                game_over <= 1'b1;
                            end else begin
                                for (int i = MAX_LEN - 1; i > 0; i--) begin
                                    seg_x[i] <= seg_x[i-1];
                                    seg_y[i] <= seg_y[i-1];
                                end
                                seg_x[0] <= nh_x;
                                seg_y[0] <= nh_y;
                                if (eat) begin
                                    if (len != LEN_MAX)  len   <= len + LW'(1);
                                    if (score != 8'hFF)  score <= score + 8'd1;
                                    state <= PLACE_FOOD;
                                end
                            end
                        end else begin
                            step_cnt <= step_cnt + 8'd1;
                        end
                    end
                end
                PLACE_FOOD: begin
                    if (cand_ok) begin
                        food_x <= cand_x;
                        food_y <= cand_y;
                        state  <= RUN;
                    end
                end
                OVER: begin
                    // Restart rebuilds the initial layout; the LFSR keeps running for fresh food.
                    if (start_rise) begin
                        state     <= RUN;
                        dir       <= DIR_RIGHT;
                        pend      <= DIR_RIGHT;
                        len       <= LEN_INIT;
                        food_x    <= 6'd30;
                        food_y    <= 5'd15;
                        step_cnt  <= 8'd0;
                        score     <= 8'd0;
                        game_over <= 1'b0;
                        for (int i = 0; i < MAX_LEN; i++) begin
                            seg_x[i] <= (i < 3) ? 6'(20 - i) : 6'd0;
                            seg_y[i] <= (i < 3) ? 5'd15 : 5'd0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_core.sv
// Bench for snake_core: pixel vector table, directed game sequences and a randomized
// run checked against a queue-based game model with full-frame colour scans.
module tb_snake_core;

    localparam int MAX_LEN = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        display;
    logic        animate;
    logic        btn_up, btn_down, btn_left, btn_right;
    logic        start;
    logic [11:0] rgb, rgb3;
    logic [7:0]  score, score3;
    logic        game_over, game_over3;
    logic [1:0]  state_dbg, state3;

    always #20 clk = ~clk;

    snake_core #(.MOVE_DIV(1), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .display(display), .animate(animate),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .start(start), .rgb(rgb), .score(score), .game_over(game_over), .state_dbg(state_dbg)
    );

    snake_core #(.MOVE_DIV(3), .MAX_LEN(MAX_LEN)) dut3 (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .display(display), .animate(animate),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .start(start), .rgb(rgb3), .score(score3), .game_over(game_over3), .state_dbg(state3)
    );

    // ---------------- reference model ----------------
    typedef struct { int cx; int cy; } cell_t;
    typedef struct { logic [9:0] px; logic [9:0] py; logic disp; logic [11:0] exp_rgb; } pix_vec_t;

    cell_t snake[$];
    int    m_dir, m_pend, m_fx, m_fy, m_score, m_state, m_place_cycles;
    bit    m_ate;
    int    tests = 0;
    int    fails = 0;
    int    ft_cnt = 0;
    logic [15:0] lfsr_m;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) lfsr_m <= 16'hACE1;
        else        lfsr_m <= lfsr_next(lfsr_m);

    always @(posedge clk)
        if (dut.frame_tick) ft_cnt <= ft_cnt + 1;

    function automatic bit on_snake(input int cx, input int cy);
        for (int i = 0; i < snake.size(); i++)
            if (snake[i].cx == cx && snake[i].cy == cy) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [11:0] exp_colour(input int cx, input int cy);
        if (snake[0].cx == cx && snake[0].cy == cy) return 12'h0F0;
        for (int i = 1; i < snake.size(); i++)
            if (snake[i].cx == cx && snake[i].cy == cy) return 12'h070;
        if (m_fx == cx && m_fy == cy) return 12'hF00;
        return (m_state == 3) ? 12'h300 : 12'h000;
    endfunction

    task automatic model_reset(input int st);
        snake.delete();
        snake.push_back(cell_t'{20, 15});
        snake.push_back(cell_t'{19, 15});
        snake.push_back(cell_t'{18, 15});
        m_dir = 3; m_pend = 3; m_fx = 30; m_fy = 15; m_score = 0; m_state = st; m_ate = 1'b0;
    endtask

    task automatic model_step();
        int nx, ny, n;
        bit hit;
        cell_t h;
        logic [15:0] l;
        m_dir = m_pend;
        m_ate = 1'b0;
        nx = snake[0].cx; ny = snake[0].cy;
        case (m_dir)
            0: ny--;
            1: ny++;
            2: nx--;
            default: nx++;
        endcase
        hit = (nx < 0) || (nx > 39) || (ny < 0) || (ny > 29);
        for (int i = 0; i < snake.size() - 1; i++)
            if (snake[i].cx == nx && snake[i].cy == ny) hit = 1'b1;
        if (hit) begin
            m_state = 3;
            return;
        end
        h.cx = nx; h.cy = ny;
        snake.push_front(h);
        if (nx == m_fx && ny == m_fy) begin
            m_ate = 1'b1;
            if (snake.size() > MAX_LEN) void'(snake.pop_back());
            if (m_score < 255) m_score++;
            m_state = 2;
            l = lfsr_m;
            n = 1;
            while (!((int'(l[5:0]) < 40) && (int'(l[12:8]) < 30) && !on_snake(int'(l[5:0]), int'(l[12:8])))
                   && n < 1000) begin
                l = lfsr_next(l);
                n++;
            end
            m_fx = int'(l[5:0]);
            m_fy = int'(l[12:8]);
            m_place_cycles = n;
        end else begin
            void'(snake.pop_back());
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_score"}, score, m_score);
        check({tag, "_game_over"}, game_over, (m_state == 3));
        check({tag, "_state"}, state_dbg, m_state);
    endtask

    task automatic scan(input string name);
        int errs, bx, by;
        logic [11:0] ba, be, e;
        errs = 0; bx = 0; by = 0; ba = 0; be = 0;
        for (int cy = 0; cy < 30; cy++) begin
            for (int cx = 0; cx < 40; cx++) begin
                x = 10'(cx * 16 + $urandom_range(0, 15));
                y = 10'(cy * 16 + $urandom_range(0, 15));
                display = 1'b1;
                @(posedge clk); #1;
                e = exp_colour(cx, cy);
                if (rgb !== e) begin
                    if (errs == 0) begin bx = cx; by = cy; ba = rgb; be = e; end
                    errs++;
                end
            end
        end
        display = 1'b0;
        tests++;
        if (errs != 0) begin
            fails++;
            $display("FAIL %s: %0d cells wrong, first (%0d,%0d) got %h want %h", name, errs, bx, by, ba, be);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        rst_n = 1'b0; start = 0; animate = 0; display = 0; x = 0; y = 0;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        model_reset(0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        if (m_state == 0)      m_state = 1;
        else if (m_state == 3) model_reset(1);
    endtask

    task automatic press(input bit u, input bit d, input bit l, input bit r);
        int req;
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
        @(posedge clk); #1;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        if (u | d | l | r) begin
            req = u ? 0 : d ? 1 : l ? 2 : 3;
            if (req != (m_dir ^ 1)) m_pend = req;
        end
    endtask

    task automatic do_tick();
        display = 1'b0; y = 10'd480; animate = 1'b0;
        @(posedge clk); #1;
        animate = 1'b1;
        @(posedge clk); #1;
        animate = 1'b0; y = 10'd0;
        m_ate = 1'b0;
        if (m_state == 1) model_step();
    endtask

    task automatic wait_place();
        int k;
        bit done;
        k = 0; done = 1'b0;
        check("place_entered", state_dbg, 2);
        for (int c = 1; c <= m_place_cycles + 20 && !done; c++) begin
            @(posedge clk); #1;
            if (state_dbg == 2'd1) begin done = 1'b1; k = c; end
        end
        check("place_cycles", k, m_place_cycles);
        m_state = 1;
    endtask

    task automatic do_step();
        do_tick();
        if (m_ate) wait_place();
    endtask

    task automatic probe(input int px, input int py);
        x = 10'(px); y = 10'(py); display = 1'b1;
        @(posedge clk); #1;
        display = 1'b0;
    endtask

    initial begin
        #3_600_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- test sequence ----------------
    initial begin
        pix_vec_t vecs[11];
        int c0, b, over_scans;

        vecs[0]  = '{10'd320, 10'd240, 1'b1, 12'h0F0};
        vecs[1]  = '{10'd700, 10'd240, 1'b0, 12'h000};
        vecs[2]  = '{10'd304, 10'd240, 1'b1, 12'h070};
        vecs[3]  = '{10'd288, 10'd250, 1'b1, 12'h070};
        vecs[4]  = '{10'd480, 10'd240, 1'b1, 12'hF00};
        vecs[5]  = '{10'd272, 10'd240, 1'b1, 12'h000};
        vecs[6]  = '{10'd335, 10'd255, 1'b1, 12'h0F0};
        vecs[7]  = '{10'd336, 10'd240, 1'b1, 12'h000};
        vecs[8]  = '{10'd320, 10'd256, 1'b1, 12'h000};
        vecs[9]  = '{10'd320, 10'd240, 1'b0, 12'h000};
        vecs[10] = '{10'd495, 10'd247, 1'b1, 12'hF00};

        rst_n = 1'b0; x = 0; y = 0; display = 0; animate = 0; start = 0;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        model_reset(0);
        repeat (3) @(posedge clk); #1;
        check("rst_state", state_dbg, 0);
        check("rst_score", score, 0);
        check("rst_game_over", game_over, 0);
        check("rst_rgb", rgb, 12'h000);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            x = vecs[i].px; y = vecs[i].py; display = vecs[i].disp;
            @(posedge clk); #1;
            check($sformatf("pix_vec%0d", i), rgb, vecs[i].exp_rgb);
        end
        display = 1'b0;
        scan("reset_frame");

        pulse_start();
        check("start_run", state_dbg, 1);

        repeat (5) do_step();
        check_status("five_steps");
        scan("five_steps_frame");
        check("div3_state", state3, 1);
        check("div3_score", score3, 0);
        probe(344, 248); check("div3_head21", rgb3, 12'h0F0);
        probe(328, 248); check("div3_body20", rgb3, 12'h070);
        probe(360, 248); check("div3_empty22", rgb3, 12'h000);

        repeat (5) do_step();
        check_status("ate_food");
        check("ate_score_one", score, 1);
        scan("ate_food_frame");

        press(0, 0, 1, 0);
        do_step();
        scan("left_ignored_frame");
        press(1, 0, 0, 0);
        do_step();
        check_status("turn_up");
        scan("turn_up_frame");

        over_scans = 0;
        for (int it = 0; it < 48; it++) begin
            b = $urandom_range(0, 5);
            case (b)
                0: press(1, 0, 0, 0);
                1: press(0, 1, 0, 0);
                2: press(0, 0, 1, 0);
                3: press(0, 0, 0, 1);
                5: press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                default: ;
            endcase
            if ($urandom_range(0, 9) == 0) pulse_start();
            do_step();
            check_status("rand");
            if (m_state == 3) begin
                if (over_scans < 3) begin
                    scan("rand_over_frame");
                    over_scans++;
                end
                pulse_start();
                check_status("rand_restart");
            end else if (it % 8 == 7) begin
                scan("rand_frame");
            end
        end

        do_reset();
        pulse_start();
        press(1, 0, 0, 0);
        do_step();
        press(0, 0, 0, 1);
        repeat (19) do_step();
        check_status("at_col39");
        do_step();
        check("wall_game_over", game_over, 1);
        check_status("wall_over");
        scan("wall_over_frame");
        pulse_start();
        check("restart_score", score, 0);
        check_status("restart");
        scan("restart_frame");

        do_reset();
        pulse_start();
        repeat (9) do_step();
        do_tick();
        check("pf_entered", state_dbg, 2);
        rst_n = 1'b0;
        model_reset(0);
        #1;
        check("pf_rst_state", state_dbg, 0);
        check("pf_rst_score", score, 0);
        check("pf_rst_game_over", game_over, 0);
        @(posedge clk); #1;
        check("pf_rst_state_edge", state_dbg, 0);
        check("pf_rst_rgb", rgb, 12'h000);
        rst_n = 1'b1;
        @(posedge clk); #1;

        c0 = ft_cnt;
        do_tick();
        y = 10'd479; animate = 1'b0;
        @(posedge clk); #1;
        animate = 1'b1;
        repeat (2) @(posedge clk);
        #1 animate = 1'b0;
        y = 10'd480;
        @(posedge clk); #1;
        animate = 1'b1;
        repeat (5) @(posedge clk);
        #1 animate = 1'b0; y = 10'd0;
        do_tick();
        @(posedge clk); #1;
        check("frame_ticks", ft_cnt - c0, 3);
        check_status("after_ticks");
        scan("idle_after_reset_frame");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
